tl_cpl_gen: RTL and testbench
=============================

# tl_cpl_gen

Completer-side completion generator for the transaction layer. Accepts non-posted memory read requests from the RX parser and reads one DW per cycle from a local memory port. Returns the data to the TX path as completion packets, splitting at MPS_DW boundaries. Tag, requester ID, byte count and lower address are carried so the remote requester's completion engine can match and reassemble.

## Interface
- TAG_W, 8, request tag width
- ADDR_W, 32, byte address width of local memory
- LEN_W, 10, request length field in DW (0 encodes 1024)
- MPS_DW, 32, max completion payload in DW; power of two, 1..1024

- clk  in  1  clock, single domain
- rst_n  in  1  reset, asynchronous assert, active-low
- req_tag_i  in  TAG_W  request tag
- req_rid_i  in  16  requester ID
- req_addr_i  in  ADDR_W  byte address; bits [1:0] ignored (DW-aligned)
- req_len_i  in  LEN_W  length in DW
- req_valid_i / req_ready_o  in / out  1  request handshake
- mem_addr_o  out  ADDR_W  DW-aligned read address
- mem_rd_en_o  out  1  read strobe; data returns exactly 1 cycle later
- mem_rdata_i  in  32  read data
- cpl_hdr_o  out  tl_pkg::cpl_hdr_t  {tag, rid, byte_cnt[11:0], lower_addr[6:0], len_dw[LEN_W-1:0]}; valid on sop beat
- cpl_data_o  out  tl_pkg::tl_data_t  one DW per beat
- cpl_sop_o / cpl_eop_o  out  1  first / last beat of a completion
- cpl_valid_o / cpl_ready_i  out / in  1  completion handshake

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: req_ready_o=1. A handshake latches tag, rid, addr, total DW (0 -> 1024); go to ISSUE.
- ISSUE: issue mem_rd_en_o with incrementing address while a credit exists. Credits: reads in flight plus 2-entry output buffer occupancy < 2. Never drop or overwrite returned data. After the last read, go to DRAIN.
- DRAIN: wait until the buffer is empty and the eop beat is transferred, then go to IDLE.
- Chunking: each completion ends at the next MPS_DW-DW address boundary or at request end, whichever comes first.
  - len_dw = DWs in the chunk.
  - byte_cnt = remaining bytes of the whole request, including this chunk. This is 4 × remaining DW, truncated to 12 bits (4096 -> 0).
  - lower_addr = chunk start address [6:0].
- Header fields are held stable from sop until the eop handshake.
- cpl_data_o, sop, eop and hdr are driven from the buffer head. Once cpl_valid_o is asserted, all outputs are held until cpl_ready_i.
- No new request is accepted until the eop of the final chunk transfers.

## Timing
- Reset values:
  - req_ready_o=1 after reset; 0 during reset.
  - mem_rd_en_o=0, mem_addr_o=0, cpl_valid_o=0, cpl_sop_o=0, cpl_eop_o=0, cpl_hdr_o=0, cpl_data_o=0.
  - FSM goes to IDLE and the buffer is empty.
- Latency:
  - Request handshake at edge T0 -> mem_rd_en_o in cycle T0+1.
  - Data captured at T0+2.
  - First cpl_valid_o in cycle T0+3.
- Throughput: one DW per cycle with cpl_ready_i held high, including across chunk boundaries (no bubble).
- Backpressure: mem_rd_en_o deasserts within the cycle credits reach 0. Reads resume the cycle after a beat drains.
- Reset mid-packet: all state is discarded and no partial eop is emitted afterwards.
- A req_valid_i held high during a busy period is taken the cycle after the last eop handshake, when req_ready_o rises.

## Structure
- In tl_pkg:
  - cpl_hdr_t struct.
  - tl_data_t, 32 bits.
  - BYTE_CNT_W=12 and LADDR_W=7 constants.
- Sub-module: tl_cpl_obuf, a 2-entry valid/ready FIFO carrying {hdr, data, sop, eop}, with count output for credit logic.
- Chunk and byte-count arithmetic stays in tl_cpl_gen.

## Test plan
- Single DW: tag=0x05, rid=0x0100, addr=0x1004, len=1 with ready high. Expect:
  - mem_addr 0x1004 read at T0+1.
  - One beat at T0+3 with sop=eop=1, byte_cnt=4, lower_addr=0x04, len_dw=1.
- MPS split: MPS_DW=32, addr=0x0F0, len=40. Expect:
  - Completion 1: len_dw=4, byte_cnt=160, lower_addr=0x70.
  - Completion 2: len_dw=32, byte_cnt=144, lower_addr=0x00.
  - Completion 3: len_dw=4, byte_cnt=16.
  - 40 beats, contiguous.
- Backpressure: len=8, with cpl_ready_i toggling 1-cycle on / 2-cycle off. Expect:
  - Data order preserved and outputs stable while stalled.
  - Never more than 2 reads plus buffered beats outstanding.
- len=0: expect 1024 beats and byte_cnt=0 on the first sop. With MPS_DW=32 and addr 0, expect 32 chunks.
- Back-to-back: second req_valid_i held during the first request. Expect req_ready_o=0 until the first eop handshake, then acceptance next cycle and correct second tag.
- Reset after 3 beats of len=8: assert rst_n low. Expect all outputs at reset values immediately and no residual beats after release. A new request must complete normally.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared transaction-layer types for the completion path.
// Header layout: {tag, rid, byte_cnt, lower_addr, len_dw}.
package tl_pkg;

  localparam int unsigned CPL_TAG_W  = 8;
  localparam int unsigned CPL_LEN_W  = 10;
  localparam int unsigned BYTE_CNT_W = 12;
  localparam int unsigned LADDR_W    = 7;

  typedef logic [31:0] tl_data_t;

  typedef struct packed {
    logic [CPL_TAG_W-1:0]  tag;
    logic [15:0]           rid;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [LADDR_W-1:0]    lower_addr;
    logic [CPL_LEN_W-1:0]  len_dw;
  } cpl_hdr_t;

  typedef struct packed {
    cpl_hdr_t hdr;
    tl_data_t data;
    logic     sop;
    logic     eop;
  } cpl_beat_t;

  // 4 bytes per DW; a full 1024-DW count wraps to 0 in the 12-bit field
  function automatic logic [BYTE_CNT_W-1:0] dw_to_byte_cnt(input logic [CPL_LEN_W:0] dw);
    return BYTE_CNT_W'({dw, 2'b00});
  endfunction

endpackage

// File: rtl/tl_cpl_obuf.sv
// Two-entry valid/ready buffer for completion beats; occupancy is exported
// so the issuer can budget outstanding reads.
module tl_cpl_obuf
  import tl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid_i,
  input  cpl_beat_t in_beat_i,
  output logic      in_ready_o,
  output logic      out_valid_o,
  output cpl_beat_t out_beat_o,
  input  logic      out_ready_i,
  output logic [1:0] count_o
);

  cpl_beat_t  mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_beat_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_beat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/tl_cpl_gen.sv
// Completion generator: reads one DW per cycle from local memory and returns
// it as completions split at MPS_DW-aligned boundaries.
module tl_cpl_gen
  import tl_pkg::*;
#(
  parameter int unsigned TAG_W  = CPL_TAG_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = CPL_LEN_W,
  parameter int unsigned MPS_DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic [15:0]       req_rid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  tl_data_t          mem_rdata_i,
  output cpl_hdr_t          cpl_hdr_o,
  output tl_data_t          cpl_data_o,
  output logic              cpl_sop_o,
  output logic              cpl_eop_o,
  output logic              cpl_valid_o,
  input  logic              cpl_ready_i
);

  localparam int unsigned CntW = LEN_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic              ready_q;
  logic [TAG_W-1:0]  tag_q;
  logic [15:0]       rid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CntW-1:0]   rem_q;
  logic              first_q;
  cpl_hdr_t          chunk_hdr_q, chunk_hdr;

  // Metadata travelling alongside the read that is in flight
  logic              rd_q;
  cpl_hdr_t          hdr_p_q;
  logic              sop_p_q, eop_p_q;

  logic [ADDR_W-3:0] dw_addr;
  logic [CntW-1:0]   off, to_bound, chunk_len;
  logic              at_sop, at_eop, accept, rd_en, pop;
  logic [2:0]        occ;
  logic [1:0]        ob_cnt;
  logic              ob_in_ready;
  cpl_beat_t         push_beat, head_beat;

  assign accept    = req_valid_i & ready_q;
  assign dw_addr   = addr_q[ADDR_W-1:2];
  assign off       = CntW'(dw_addr & (ADDR_W-2)'(MPS_DW - 1));
  assign to_bound  = CntW'(MPS_DW) - off;
  assign chunk_len = (rem_q < to_bound) ? rem_q : to_bound;
  assign at_sop    = first_q | (off == '0);
  assign at_eop    = (rem_q == CntW'(1)) | (off == CntW'(MPS_DW - 1));

  always_comb begin
    chunk_hdr = chunk_hdr_q;
    if (at_sop) begin
      chunk_hdr.tag        = tag_q;
      chunk_hdr.rid        = rid_q;
      chunk_hdr.byte_cnt   = dw_to_byte_cnt(rem_q);
      chunk_hdr.lower_addr = addr_q[LADDR_W-1:0];
      chunk_hdr.len_dw     = LEN_W'(chunk_len);
    end
  end

  // A beat leaving this cycle frees its slot for a read issued this cycle
  assign pop   = cpl_valid_o & cpl_ready_i;
  assign occ   = {2'b0, rd_q} + {1'b0, ob_cnt} - {2'b0, pop};
  assign rd_en = (state_q == StIssue) & (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (rd_en && rem_q == CntW'(1)) state_d = StDrain;
      StDrain: if (!rd_q && ob_cnt == 2'd1 && pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      tag_q       <= '0;
      rid_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      chunk_hdr_q <= '0;
      rd_q        <= 1'b0;
      hdr_p_q     <= '0;
      sop_p_q     <= 1'b0;
      eop_p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      rd_q    <= rd_en;
      if (accept) begin
        tag_q   <= req_tag_i;
        rid_q   <= req_rid_i;
        addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
        rem_q   <= (req_len_i == '0) ? {1'b1, LEN_W'(0)} : {1'b0, req_len_i};
        first_q <= 1'b1;
      end
      if (rd_en) begin
        addr_q      <= addr_q + ADDR_W'(4);
        rem_q       <= rem_q - CntW'(1);
        first_q     <= 1'b0;
        chunk_hdr_q <= chunk_hdr;
        hdr_p_q     <= chunk_hdr;
        sop_p_q     <= at_sop;
        eop_p_q     <= at_eop;
      end
    end
  end

  assign push_beat = '{hdr: hdr_p_q, data: mem_rdata_i, sop: sop_p_q, eop: eop_p_q};

  tl_cpl_obuf u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (rd_q),
    .in_beat_i   (push_beat),
    .in_ready_o  (ob_in_ready),
    .out_valid_o (cpl_valid_o),
    .out_beat_o  (head_beat),
    .out_ready_i (cpl_ready_i),
    .count_o     (ob_cnt)
  );

  // Credits guarantee returned data always finds a free slot
  assert property (@(posedge clk) disable iff (!rst_n) rd_q |-> ob_in_ready);

  assign req_ready_o = ready_q;
  assign mem_addr_o  = addr_q;
  assign mem_rd_en_o = rd_en;
  assign cpl_hdr_o   = head_beat.hdr;
  assign cpl_data_o  = head_beat.data;
  assign cpl_sop_o   = head_beat.sop;
  assign cpl_eop_o   = head_beat.eop;

endmodule

// File: tb/tb_tl_cpl_gen.sv
// Randomised bench for tl_cpl_gen against a per-request beat-list model.
module tb_tl_cpl_gen;
  import tl_pkg::*;

  localparam int unsigned MPS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req_tag;
  logic [15:0] req_rid;
  logic [31:0] req_addr;
  logic [9:0]  req_len;
  logic        req_valid, req_ready;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  tl_data_t    mem_rdata;
  cpl_hdr_t    cpl_hdr;
  tl_data_t    cpl_data;
  logic        cpl_sop, cpl_eop, cpl_valid, cpl_ready;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int rd_total = 0;
  int xfer_total = 0;
  logic [127:0] exp_q[$];
  cpl_hdr_t     sop_hdrs[$];

  tl_cpl_gen #(.TAG_W(8), .ADDR_W(32), .LEN_W(10), .MPS_DW(MPS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_tag_i   (req_tag),
    .req_rid_i   (req_rid),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .mem_addr_o  (mem_addr),
    .mem_rd_en_o (mem_rd_en),
    .mem_rdata_i (mem_rdata),
    .cpl_hdr_o   (cpl_hdr),
    .cpl_data_o  (cpl_data),
    .cpl_sop_o   (cpl_sop),
    .cpl_eop_o   (cpl_eop),
    .cpl_valid_o (cpl_valid),
    .cpl_ready_i (cpl_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic tl_data_t mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Local memory: data for the sampled address one cycle after the strobe
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_fn(mem_addr) : $urandom;

  initial begin
    int phase = 0;
    cpl_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: cpl_ready = 1'b1;
        1: begin cpl_ready = (phase == 0); phase = (phase + 1) % 3; end
        default: cpl_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Expected beats of one request, derived from the chunking rules
  function automatic void push_expected(input logic [7:0] tag, input logic [15:0] rid,
                                        input logic [31:0] addr, input logic [9:0] len);
    int unsigned n, dw0, dw, off, clen, bc, la;
    logic sop, eop;
    n = (len == 10'd0) ? 1024 : {22'b0, len};
    dw0 = addr >> 2;
    clen = 0; bc = 0; la = 0;
    for (int unsigned i = 0; i < n; i++) begin
      dw  = dw0 + i;
      off = dw % MPS;
      sop = (i == 0) || (off == 0);
      eop = (i == n - 1) || (off == MPS - 1);
      if (sop) begin
        clen = MPS - off;
        if (n - i < clen) clen = n - i;
        bc = ((n - i) * 4) % 4096;
        la = (dw * 4) % 128;
      end
      exp_q.push_back({41'b0, tag, rid, bc[11:0], la[6:0], clen[9:0], mem_fn(dw * 4), sop, eop});
    end
  endfunction

  always @(negedge clk) begin
    logic [127:0] obs;
    static logic stalled = 1'b0;
    static logic [127:0] held = '0;
    obs = {41'b0, cpl_hdr, cpl_data, cpl_sop, cpl_eop};
    if (!rst_n) begin
      stalled = 1'b0;
      rd_total = 0;
      xfer_total = 0;
    end else begin
      if (stalled) check("stall_hold", {cpl_valid, obs[86:0]}, {1'b1, held[86:0]});
      if (mem_rd_en) rd_total++;
      if (cpl_valid && cpl_ready) begin
        xfer_total++;
        if (cpl_sop) sop_hdrs.push_back(cpl_hdr);
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", obs, exp_q.pop_front());
      end
      if (mem_rd_en) check("credit_over_2", (rd_total - xfer_total) > 2, 0);
      stalled = cpl_valid && !cpl_ready;
      held = obs;
    end
  end

  task automatic send_req(input logic [7:0] tag, input logic [15:0] rid,
                          input logic [31:0] addr, input logic [9:0] len);
    int w = 0;
    @(posedge clk);
    #1;
    req_tag = tag; req_rid = rid; req_addr = addr; req_len = len; req_valid = 1'b1;
    do begin @(negedge clk); w++; end while (!req_ready && w < 5000);
    if (!req_ready) check("req_accept_timeout", 0, 1);
    else push_expected(tag, rid, addr, len);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w = 0;
    while ((exp_q.size() != 0 || !req_ready) && w < budget) begin @(negedge clk); w++; end
    check("drain_done", (exp_q.size() == 0) && req_ready, 1);
  endtask

  task automatic wait_valid(input int budget);
    int w = 0;
    while (!cpl_valid && w < budget) begin @(negedge clk); w++; end
    check("first_valid_seen", cpl_valid, 1);
  endtask

  initial begin
    int nv;
    logic seen, busy_bad;
    rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_rid = '0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_outs", {mem_rd_en, cpl_valid, cpl_sop, cpl_eop, mem_addr, cpl_hdr, cpl_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // Single DW with latency
    rdy_mode = 0;
    send_req(8'h05, 16'h0100, 32'h1004, 10'd1);
    @(negedge clk);
    check("t1_rd_en", mem_rd_en, 1);
    check("t1_addr", mem_addr, 32'h1004);
    @(negedge clk);
    check("t1_early_valid", cpl_valid, 0);
    @(negedge clk);
    check("t1_valid", cpl_valid, 1);
    check("t1_sop_eop", {cpl_sop, cpl_eop}, 2'b11);
    check("t1_byte_cnt", cpl_hdr.byte_cnt, 12'd4);
    check("t1_lower_addr", cpl_hdr.lower_addr, 7'h04);
    check("t1_len_dw", cpl_hdr.len_dw, 10'd1);
    wait_drain(100);

    // MPS split, contiguous beats
    sop_hdrs.delete();
    send_req(8'h11, 16'h0200, 32'h0000_00F0, 10'd40);
    wait_valid(20);
    nv = 1;
    repeat (39) begin @(negedge clk); if (cpl_valid) nv++; end
    check("t2_contiguous", nv, 40);
    wait_drain(200);
    check("t2_chunks", sop_hdrs.size(), 3);
    if (sop_hdrs.size() == 3) begin
      check("t2_c1", {sop_hdrs[0].len_dw, sop_hdrs[0].byte_cnt, sop_hdrs[0].lower_addr},
            {10'd4, 12'd160, 7'h70});
      check("t2_c2", {sop_hdrs[1].len_dw, sop_hdrs[1].byte_cnt, sop_hdrs[1].lower_addr},
            {10'd32, 12'd144, 7'h00});
      check("t2_c3", {sop_hdrs[2].len_dw, sop_hdrs[2].byte_cnt}, {10'd4, 12'd16});
    end

    // Backpressure 1 on / 2 off
    rdy_mode = 1;
    send_req(8'h22, 16'h0300, 32'h0000_0200, 10'd8);
    wait_drain(300);

    // len=0 -> 1024 DW in 32 chunks
    rdy_mode = 0;
    sop_hdrs.delete();
    send_req(8'h33, 16'h0400, 32'h0, 10'd0);
    wait_drain(3000);
    check("t4_chunks", sop_hdrs.size(), 32);
    if (sop_hdrs.size() > 0)
      check("t4_first", {sop_hdrs[0].byte_cnt, sop_hdrs[0].len_dw}, {12'd0, 10'd32});

    // Back-to-back with second request held valid
    sop_hdrs.delete();
    send_req(8'h44, 16'h0500, 32'h0000_0400, 10'd5);
    req_tag = 8'h55; req_rid = 16'h0600; req_addr = 32'h0000_0800; req_len = 10'd3;
    req_valid = 1'b1;
    seen = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) busy_bad = 1'b1;
      if (cpl_valid && cpl_ready && cpl_eop) seen = 1'b1;
    end
    check("t5_ready_low_busy", busy_bad, 0);
    @(negedge clk);
    check("t5_ready_rise", req_ready, 1);
    push_expected(8'h55, 16'h0600, 32'h0000_0800, 10'd3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_drain(100);
    check("t5_hdr_count", sop_hdrs.size(), 2);
    if (sop_hdrs.size() == 2) check("t5_second_tag", sop_hdrs[1].tag, 8'h55);

    // Reset after 3 beats
    send_req(8'h66, 16'h0700, 32'h0000_0C00, 10'd8);
    nv = 0;
    while (xfer_total < 3 && nv < 50) begin @(negedge clk); #2; nv++; end
    check("t6_three_beats", xfer_total >= 3, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {req_ready, mem_rd_en, cpl_valid, cpl_sop, cpl_eop, mem_addr,
                          cpl_hdr, cpl_data}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nv = 0;
    repeat (12) begin @(negedge clk); if (cpl_valid) nv++; end
    check("t6_no_residual", nv, 0);
    send_req(8'h77, 16'h0800, 32'h0000_1000, 10'd6);
    wait_drain(100);

    // Random requests with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 25; i++)
      send_req(8'($urandom), 16'($urandom), $urandom & 32'h0000_FFFF,
               10'($urandom_range(1, 70)));
    wait_drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
